// File: rtl/i2s_slave_rx.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_slave_rx
//  Description : I2S receiver for an externally mastered bus. Synchronises
//                sck/ws/sd into the ck domain and emits left/right pairs.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_slave_rx #(
   parameter int WIDTH    = 16,
   parameter int SLOT_MAX = 32
) (
   input  logic             ck,
   input  logic             rst_n,
   input  logic             sck,
   input  logic             ws,
   input  logic             sd,
   output logic [WIDTH-1:0] left,
   output logic [WIDTH-1:0] right,
   output logic             valid,
   output logic [5:0]       frame_posn,
   output logic             locked,
   output logic             frame_err
);

   localparam logic [5:0] c_width    = 6'(WIDTH);
   localparam logic [5:0] c_slot_max = 6'(SLOT_MAX);

   generate
      if (WIDTH < 2 || WIDTH > SLOT_MAX || SLOT_MAX > 32) begin : g_param_check
         $error("i2s_slave_rx: illegal WIDTH/SLOT_MAX combination");
      end
   endgenerate

   logic             r_sck_s1, r_sck_s2, r_sck_s3;
   logic             r_ws_s1,  r_ws_s2;
   logic             r_sd_s1,  r_sd_s2;
   logic             w_rise;

   logic             r_ws_last;
   logic             r_ws_slot;
   logic [5:0]       r_bit_cnt;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] r_left_pend;
   logic             r_left_ok;
   logic             r_armed;

   logic             w_ws_change;
   logic             w_take;
   logic [WIDTH-1:0] w_word;
   logic [5:0]       w_len;
   logic             w_slot_good;
   logic             w_overrun;
   logic [5:0]       w_cnt_next;
   logic             w_slot_next;
   logic [5:0]       w_posn_next;

   // ws and sd share the sck sync depth so they line up with the detected rise
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         r_sck_s1 <= 1'b0;
         r_sck_s2 <= 1'b0;
         r_sck_s3 <= 1'b0;
         r_ws_s1  <= 1'b0;
         r_ws_s2  <= 1'b0;
         r_sd_s1  <= 1'b0;
         r_sd_s2  <= 1'b0;
      end else begin
         r_sck_s1 <= sck;
         r_sck_s2 <= r_sck_s1;
         r_sck_s3 <= r_sck_s2;
         r_ws_s1  <= ws;
         r_ws_s2  <= r_ws_s1;
         r_sd_s1  <= sd;
         r_sd_s2  <= r_sd_s1;
      end
   end

   assign w_rise = r_sck_s2 & ~r_sck_s3;

   always_comb begin
      w_ws_change = (r_ws_s2 != r_ws_last);
      w_take      = (r_bit_cnt < c_width);
      w_word      = w_take ? {r_shift[WIDTH-2:0], r_sd_s2} : r_shift;
      // the bit on the ws-change rise still belongs to the ending slot
      w_len       = r_bit_cnt + 6'd1;
      w_slot_good = r_armed && (w_len >= c_width) && (w_len <= c_slot_max);
      w_overrun   = !w_ws_change && r_armed && (r_bit_cnt == c_slot_max);
      if (w_ws_change) begin
         w_cnt_next = 6'd0;
      end else if (r_bit_cnt == c_slot_max) begin
         w_cnt_next = r_bit_cnt;
      end else begin
         w_cnt_next = r_bit_cnt + 6'd1;
      end
      w_slot_next = w_ws_change ? r_ws_s2 : r_ws_slot;
      w_posn_next = {w_slot_next, (w_cnt_next > 6'd31) ? 5'd31 : w_cnt_next[4:0]};
   end

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         r_ws_last  <= 1'b0;
         r_ws_slot  <= 1'b0;
         r_bit_cnt  <= 6'd0;
         r_shift    <= '0;
         r_armed    <= 1'b0;
         frame_posn <= 6'd0;
      end else if (w_rise) begin
         r_ws_last  <= r_ws_s2;
         r_ws_slot  <= w_slot_next;
         r_bit_cnt  <= w_cnt_next;
         frame_posn <= w_posn_next;
         if (w_ws_change) begin
            r_shift <= '0;
            r_armed <= 1'b1;
         end else begin
            r_shift <= w_word;
            if (w_overrun) begin
               r_armed <= 1'b0;
            end
         end
      end
   end

   // left is held back until its matching right slot completes cleanly
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         r_left_pend <= '0;
         r_left_ok   <= 1'b0;
         left        <= '0;
         right       <= '0;
         valid       <= 1'b0;
         locked      <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         valid     <= 1'b0;
         frame_err <= 1'b0;
         if (w_rise) begin
            if (w_ws_change) begin
               if (w_slot_good) begin
                  if (!r_ws_last) begin
                     r_left_pend <= w_word;
                     r_left_ok   <= 1'b1;
                  end else if (r_left_ok) begin
                     left      <= r_left_pend;
                     right     <= w_word;
                     valid     <= 1'b1;
                     locked    <= 1'b1;
                     r_left_ok <= 1'b0;
                  end
               end else begin
                  r_left_ok <= 1'b0;
                  locked    <= 1'b0;
               end
            end else if (w_overrun) begin
               frame_err <= 1'b1;
               locked    <= 1'b0;
               r_left_ok <= 1'b0;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_i2s_slave_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_slave_rx
//  Description : Directed self-checking bench for i2s_slave_rx with a simple
//                I2S master model driving sck/ws/sd.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_slave_rx;

   logic        ck = 1'b0;
   logic        rst_n;
   logic        sck;
   logic        ws;
   logic        sd;
   logic [15:0] left;
   logic [15:0] right;
   logic        valid;
   logic [5:0]  frame_posn;
   logic        locked;
   logic        frame_err;

   int half_ns   = 40;
   int total     = 0;
   int passed    = 0;
   int valid_cnt = 0;
   int err_cnt   = 0;

   i2s_slave_rx #(.WIDTH(16), .SLOT_MAX(32)) dut (
      .ck         (ck),
      .rst_n      (rst_n),
      .sck        (sck),
      .ws         (ws),
      .sd         (sd),
      .left       (left),
      .right      (right),
      .valid      (valid),
      .frame_posn (frame_posn),
      .locked     (locked),
      .frame_err  (frame_err)
   );

   always #5 ck = ~ck;

   // pulse counters; a stuck-high strobe shows up as extra counts
   always @(negedge ck) begin
      if (valid === 1'b1)     valid_cnt <= valid_cnt + 1;
      if (frame_err === 1'b1) err_cnt   <= err_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // the last bit of a slot carries the next slot's ws (one-bit I2S delay)
   task automatic send_slot(input logic slot_ws, input logic next_ws,
                            input logic [31:0] word, input int len);
      for (int j = 0; j < len; j++) begin
         sck = 1'b0;
         ws  = (j == len - 1) ? next_ws : slot_ws;
         sd  = word[31 - j];
         #(half_ns);
         sck = 1'b1;
         #(half_ns);
      end
   endtask

   task automatic send_frame(input logic [31:0] lw, input logic [31:0] rw, input int len);
      send_slot(1'b0, 1'b1, lw, len);
      send_slot(1'b1, 1'b0, rw, len);
   endtask

   task automatic settle();
      sck = 1'b0;
      repeat (6) @(posedge ck);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      sck   = 1'b0;
      ws    = 1'b0;
      sd    = 1'b0;
      repeat (4) @(posedge ck);
      #1;
      check("rst_left",   32'(left),       32'h0);
      check("rst_right",  32'(right),      32'h0);
      check("rst_valid",  32'(valid),      32'h0);
      check("rst_posn",   32'(frame_posn), 32'h0);
      check("rst_locked", 32'(locked),     32'h0);
      check("rst_err",    32'(frame_err),  32'h0);
      rst_n = 1'b1;
      repeat (2) @(posedge ck);

      // first frame after reset is discarded
      send_frame(32'h1111_0000, 32'h2222_0000, 32);
      settle();
      check("disc_valid",  32'(valid_cnt), 32'd0);
      check("disc_locked", 32'(locked),    32'h0);

      send_slot(1'b0, 1'b1, 32'h8234_1234, 32);
      settle();
      check("posn_right_msb", 32'(frame_posn), 32'd32);
      send_slot(1'b1, 1'b0, 32'h8235_5678, 32);
      settle();
      check("f1_valid",  32'(valid_cnt), 32'd1);
      check("f1_left",   32'(left),      32'h8234);
      check("f1_right",  32'(right),     32'h8235);
      check("f1_locked", 32'(locked),    32'h1);

      send_frame(32'h0001_FFFF, 32'hFFFE_0000, 32);
      settle();
      check("f2_left",  32'(left),      32'h0001);
      check("f2_right", 32'(right),     32'hFFFE);
      check("f2_valid", 32'(valid_cnt), 32'd2);

      // 24-bit slots keep the top 16 bits
      send_frame(32'h1234_5600, 32'hABCD_EF00, 24);
      settle();
      check("s24_left",  32'(left),  32'h1234);
      check("s24_right", 32'(right), 32'hABCD);

      // exact-WIDTH slots
      repeat (3) send_frame(32'hA5A5_0000, 32'h5A5A_0000, 16);
      settle();
      check("s16_left",   32'(left),      32'hA5A5);
      check("s16_right",  32'(right),     32'h5A5A);
      check("s16_valid",  32'(valid_cnt), 32'd6);
      check("s16_locked", 32'(locked),    32'h1);
      check("s16_err",    32'(err_cnt),   32'd0);

      // ws held low for 39 bits: overrun on the 33rd
      send_slot(1'b0, 1'b0, 32'hFFFF_FFFF, 32);
      send_slot(1'b0, 1'b0, 32'h0000_0000, 7);
      settle();
      check("ovr_err",    32'(err_cnt),    32'd1);
      check("ovr_locked", 32'(locked),     32'h0);
      check("ovr_posn",   32'(frame_posn), 32'd31);
      check("ovr_hold",   32'(left),       32'hA5A5);
      send_slot(1'b0, 1'b1, 32'h0000_0000, 1);
      send_slot(1'b1, 1'b0, 32'h9999_0000, 32);
      settle();
      check("ovr_disc_valid", 32'(valid_cnt), 32'd6);
      send_frame(32'h3C3C_0000, 32'hC3C3_0000, 32);
      settle();
      check("rec_valid",  32'(valid_cnt), 32'd7);
      check("rec_left",   32'(left),      32'h3C3C);
      check("rec_right",  32'(right),     32'hC3C3);
      check("rec_locked", 32'(locked),    32'h1);
      check("rec_err",    32'(err_cnt),   32'd1);

      // 12-bit left slot is too short
      send_slot(1'b0, 1'b1, 32'hFFF0_0000, 12);
      settle();
      check("short_locked", 32'(locked), 32'h0);
      send_slot(1'b1, 1'b0, 32'h1234_0000, 32);
      settle();
      check("short_valid", 32'(valid_cnt), 32'd7);
      send_frame(32'h0F0F_0000, 32'hF0F0_0000, 32);
      settle();
      check("relock_valid",  32'(valid_cnt), 32'd8);
      check("relock_locked", 32'(locked),    32'h1);
      check("relock_left",   32'(left),      32'h0F0F);
      check("relock_right",  32'(right),     32'hF0F0);

      // reset in the middle of a right slot
      send_slot(1'b0, 1'b1, 32'h5555_0000, 32);
      send_slot(1'b1, 1'b1, 32'hAAAA_0000, 10);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_left",   32'(left),       32'h0);
      check("arst_right",  32'(right),      32'h0);
      check("arst_locked", 32'(locked),     32'h0);
      check("arst_posn",   32'(frame_posn), 32'h0);
      check("arst_valid",  32'(valid),      32'h0);
      sck = 1'b0;
      repeat (3) @(posedge ck);
      #2;
      rst_n = 1'b1;

      // sck at ck/4 with an arbitrary phase against ck
      half_ns = 20;
      @(posedge ck);
      #($urandom_range(9, 1));
      send_slot(1'b1, 1'b0, 32'h0000_0000, 22);
      settle();
      check("post_rst_disc", 32'(valid_cnt), 32'd8);
      send_frame(32'h6B6B_0000, 32'hB6B6_0000, 32);
      settle();
      check("fast_valid",  32'(valid_cnt), 32'd9);
      check("fast_left",   32'(left),      32'h6B6B);
      check("fast_right",  32'(right),     32'hB6B6);
      check("fast_locked", 32'(locked),    32'h1);
      send_frame(32'h1357_0000, 32'h2468_0000, 16);
      settle();
      check("fast16_left",  32'(left),      32'h1357);
      check("fast16_right", 32'(right),     32'h2468);
      check("fast16_valid", 32'(valid_cnt), 32'd10);
      check("final_err",    32'(err_cnt),   32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
